// File: rtl/countdown_timer_pkg.sv
// Shared types, constants and helpers for the BCD MM:SS countdown timer.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_e;

   localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
   localparam logic [3:0]  BCD_MAX      = 4'd9;
   localparam logic [15:0] ZERO_TIME    = 16'h0000;

   // A load is acceptable only if every digit is a legal BCD digit for its position.
   function automatic logic load_valid(input logic [7:0] min_val, input logic [7:0] sec_val);
      return (min_val[7:4] <= BCD_MAX) && (min_val[3:0] <= BCD_MAX) &&
             (sec_val[7:4] <= SEC_TENS_MAX) && (sec_val[3:0] <= BCD_MAX);
   endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronizes the divided slow-clock level into clk and emits one pulse per rising edge.
module tick_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise_pulse
);

   localparam int unsigned FILL_MAX = SYNC_STAGES + 1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [2:0]             fill_q, fill_d;

   // Shift the input through the synchronizer; the edge detector stays disarmed until
   // the chain and history flop hold real samples, so a level already high at reset
   // release is not mistaken for a rising edge.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], async_in};
      hist_d     = sync_q[SYNC_STAGES-1];
      fill_d     = (fill_q == 3'(FILL_MAX)) ? fill_q : fill_q + 3'd1;
      rise_pulse = (fill_q == 3'(FILL_MAX)) & sync_q[SYNC_STAGES-1] & ~hist_q;
   end

   // Synchronizer, history and fill-counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         fill_q <= '0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Loadable BCD MM:SS countdown timer driven by rising edges of a divided tick level.
module countdown_timer_bcd
   import countdown_timer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       expired,
   output logic       done,
   output logic       load_err
);

   state_e     state_q, state_d;
   logic [7:0] min_q, min_d, sec_q, sec_d;
   logic       running_q, running_d, expired_q, expired_d;
   logic       done_q, done_d, load_err_q, load_err_d;

   logic       tick;
   logic [3:0] su_dec, st_dec, mu_dec, mt_dec;
   logic       borrow_su, borrow_st, borrow_mu;
   logic [15:0] count_dec;

   tick_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_tick_sync (
      .clk       (clk),
      .reset     (reset),
      .async_in  (tick_in),
      .rise_pulse(tick)
   );

   // One-step BCD decrement as a borrow chain from seconds units up to minutes tens.
   always_comb begin
      borrow_su = (sec_q[3:0] == 4'd0);
      su_dec    = borrow_su ? BCD_MAX : sec_q[3:0] - 4'd1;
      borrow_st = borrow_su & (sec_q[7:4] == 4'd0);
      st_dec    = borrow_su ? (borrow_st ? SEC_TENS_MAX : sec_q[7:4] - 4'd1) : sec_q[7:4];
      borrow_mu = borrow_st & (min_q[3:0] == 4'd0);
      mu_dec    = borrow_st ? (borrow_mu ? BCD_MAX : min_q[3:0] - 4'd1) : min_q[3:0];
      mt_dec    = borrow_mu ? min_q[7:4] - 4'd1 : min_q[7:4];
      count_dec = {mt_dec, mu_dec, st_dec, su_dec};
   end

   // Next-state logic: load > start > pause, decrement only when no command acts.
   always_comb begin
      state_d    = state_q;
      min_d      = min_q;
      sec_d      = sec_q;
      done_d     = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_valid(load_min, load_sec)) begin
            min_d   = load_min;
            sec_d   = load_sec;
            state_d = IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (start && (state_q == IDLE || state_q == PAUSED) &&
                   ({min_q, sec_q} != ZERO_TIME)) begin
         state_d = RUN;
      end else if (!start && pause && state_q == RUN) begin
         state_d = PAUSED;
      end else if (state_q == RUN && tick) begin
         min_d = count_dec[15:8];
         sec_d = count_dec[7:0];
         if (count_dec == ZERO_TIME) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
         end
      end
      running_d = (state_d == RUN);
      expired_d = (state_d == EXPIRED);
   end

   // State, count and registered output flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         min_q      <= '0;
         sec_q      <= '0;
         running_q  <= 1'b0;
         expired_q  <= 1'b0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         running_q  <= running_d;
         expired_q  <= expired_d;
         done_q     <= done_d;
         load_err_q <= load_err_d;
      end
   end

   assign min_bcd  = min_q;
   assign sec_bcd  = sec_q;
   assign running  = running_q;
   assign expired  = expired_q;
   assign done     = done_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench for countdown_timer_bcd: seconds-based reference model plus directed literals.
module tb_countdown_timer_bcd;

   localparam int N = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_in = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_min = 8'h00;
   logic [7:0] load_sec = 8'h00;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] min_bcd, sec_bcd;
   logic       running, expired, done, load_err;

   int errors = 0;
   int checks = 0;

   // Reference model: total remaining seconds, abstract state, recent tick_in samples
   // (2 marks a sample slot not yet filled since reset).
   int m_total;
   int m_state;
   int m_done;
   int m_err;
   int smp[0:N+1];
   bit m_tick;

   countdown_timer_bcd #(
      .SYNC_STAGES(N)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tick_in (tick_in),
      .load    (load),
      .load_min(load_min),
      .load_sec(load_sec),
      .start   (start),
      .pause   (pause),
      .min_bcd (min_bcd),
      .sec_bcd (sec_bcd),
      .running (running),
      .expired (expired),
      .done    (done),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
      end
   endtask

   function automatic int to_bcd(input int v);
      return ((v / 10) << 4) | (v % 10);
   endfunction

   // Model update on each clock edge (asynchronous reset clears everything).
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_total = 0;
         m_state = M_IDLE;
         m_done  = 0;
         m_err   = 0;
         for (int i = 0; i <= N + 1; i++) smp[i] = 2;
      end else begin
         // tick seen at this edge: sample N edges back high, sample N+1 edges back low
         m_tick = (smp[N-1] == 1) && (smp[N] == 0);
         for (int i = N + 1; i > 0; i--) smp[i] = smp[i-1];
         smp[0] = int'(tick_in);
         m_done = 0;
         m_err  = 0;
         if (load) begin
            if (load_min[7:4] <= 9 && load_min[3:0] <= 9 && load_sec[7:4] <= 5 && load_sec[3:0] <= 9) begin
               m_total = (int'(load_min[7:4]) * 10 + int'(load_min[3:0])) * 60 +
                         int'(load_sec[7:4]) * 10 + int'(load_sec[3:0]);
               m_state = M_IDLE;
            end else begin
               m_err = 1;
            end
         end else if (start && (m_state == M_IDLE || m_state == M_PAUSED) && m_total != 0) begin
            m_state = M_RUN;
         end else if (!start && pause && m_state == M_RUN) begin
            m_state = M_PAUSED;
         end else if (m_state == M_RUN && m_tick) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
               m_state = M_EXPIRED;
               m_done  = 1;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         check("min_bcd",  int'(min_bcd),  to_bcd(m_total / 60));
         check("sec_bcd",  int'(sec_bcd),  to_bcd(m_total % 60));
         check("running",  int'(running),  int'(m_state == M_RUN));
         check("expired",  int'(expired),  int'(m_state == M_EXPIRED));
         check("done",     int'(done),     m_done);
         check("load_err", int'(load_err), m_err);
      end
   end

   task automatic do_load(input logic [7:0] m, input logic [7:0] s, input bit with_start);
      load     = 1'b1;
      load_min = m;
      load_sec = s;
      start    = with_start;
      @(negedge clk);
      load  = 1'b0;
      start = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_pause();
      pause = 1'b1;
      @(negedge clk);
      pause = 1'b0;
   endtask

   task automatic tick_edge();
      tick_in = 1'b1;
      repeat (4) @(negedge clk);
      tick_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_min", int'(min_bcd), 'h00);
      check("rst_sec", int'(sec_bcd), 'h00);
      check("rst_flags", int'({running, expired, done, load_err}), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // borrow chain
      do_load(8'h10, 8'h00, 1'b0);
      do_start();
      tick_edge();
      check("borrow_min", int'(min_bcd), 'h09);
      check("borrow_sec", int'(sec_bcd), 'h59);
      tick_edge();
      check("borrow2_sec", int'(sec_bcd), 'h58);

      // expiry and done pulse
      do_load(8'h00, 8'h02, 1'b0);
      do_start();
      tick_edge();
      check("exp_first", int'(sec_bcd), 'h01);
      tick_in = 1'b1;
      repeat (3) @(negedge clk);
      check("exp_zero", int'({min_bcd, sec_bcd}), 'h0000);
      check("exp_flag", int'(expired), 1);
      check("exp_done_hi", int'(done), 1);
      @(negedge clk);
      check("exp_done_lo", int'(done), 0);
      tick_in = 1'b0;
      repeat (4) @(negedge clk);
      tick_edge();
      do_start();
      tick_edge();
      check("exp_hold", int'({min_bcd, sec_bcd, expired}), 'h00001);

      // invalid load and command priority
      do_load(8'h00, 8'h20, 1'b0);
      do_start();
      do_load(8'h00, 8'h61, 1'b0);
      check("bad_load_err", int'(load_err), 1);
      check("bad_load_keep", int'({sec_bcd, running}), 'h41);
      do_load(8'h00, 8'h45, 1'b1);
      check("load_over_start", int'({sec_bcd, running}), 'h8a);

      // tick coinciding with start from IDLE, then a long held-high level
      tick_in = 1'b1;
      repeat (2) @(negedge clk);
      do_start();
      check("start_tick", int'({sec_bcd, running}), 'h8b);
      tick_in = 1'b0;
      repeat (5) @(negedge clk);
      tick_in = 1'b1;
      repeat (1000) @(negedge clk);
      check("held_high", int'(sec_bcd), 'h44);
      tick_in = 1'b0;
      repeat (5) @(negedge clk);

      // pause / resume
      do_load(8'h00, 8'h30, 1'b0);
      do_start();
      tick_edge();
      check("pr_first", int'(sec_bcd), 'h29);
      do_pause();
      repeat (3) tick_edge();
      check("pr_paused", int'({sec_bcd, running}), 'h52);
      do_start();
      tick_edge();
      check("pr_resumed", int'(sec_bcd), 'h28);

      // reset mid-run with tick_in held high across release
      do_load(8'h01, 8'h05, 1'b0);
      do_start();
      tick_edge();
      check("rr_pre", int'({min_bcd, sec_bcd}), 'h0104);
      tick_in = 1'b1;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rr_async_cnt", int'({min_bcd, sec_bcd}), 'h0000);
      check("rr_async_run", int'(running), 0);
      @(negedge clk);
      reset = 1'b0;
      do_load(8'h00, 8'h03, 1'b0);
      do_start();
      repeat (20) @(negedge clk);
      check("rr_no_tick", int'({sec_bcd, running}), 'h07);
      tick_in = 1'b0;
      repeat (5) @(negedge clk);
      tick_edge();
      check("rr_fresh_tick", int'(sec_bcd), 'h02);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
